// File: rtl/ifetch_prefetch.sv
// Instruction fetch/prefetch stage: drives the OTP address, buffers returned words in a small FIFO.
// Optional fetch counter enabled by defining IFETCH_PERF_CNT_EN.
module ifetch_prefetch #(
   parameter int unsigned DEPTH    = 2,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   output logic [31:0] otp_pa,
   input  logic [31:0] otp_pdataout,
   input  logic        fetch_en,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        instr_valid,
   input  logic        instr_ready,
   output logic [31:0] instr,
   output logic [31:0] instr_pc,
   output logic [31:0] perf_fetch_cnt
);

   localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CntW = PtrW + 1;
   localparam logic [CntW-1:0] DepthC = CntW'(DEPTH);

   logic [31:0]     fetch_pc_q, fetch_pc_d;
   logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CntW-1:0] count_q, count_d;
   logic [31:0]     pc_mem_q   [DEPTH];
   logic [31:0]     word_mem_q [DEPTH];
   logic            push, pop;

   // Low address bits of a redirect target are dropped by construction.
   logic unused_redirect_lsb;
   assign unused_redirect_lsb = ^redirect_pc[1:0];

   assign otp_pa      = fetch_pc_q;
   assign instr_valid = (count_q != '0);
   assign instr       = word_mem_q[rd_ptr_q];
   assign instr_pc    = pc_mem_q[rd_ptr_q];

   always_comb begin
      pop        = instr_valid && instr_ready;
      push       = fetch_en && !redirect_valid && ((count_q < DepthC) || pop);
      fetch_pc_d = fetch_pc_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      if (redirect_valid) begin
         fetch_pc_d = {redirect_pc[31:2], 2'b00};
         wr_ptr_d   = '0;
         rd_ptr_d   = '0;
         count_d    = '0;
      end else begin
         if (push) begin
            wr_ptr_d   = wr_ptr_q + 1'b1;
            fetch_pc_d = fetch_pc_q + 32'd4;
         end
         if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
         end
         count_d = count_q + CntW'(push) - CntW'(pop);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         fetch_pc_q <= RESET_PC;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
      end else begin
         fetch_pc_q <= fetch_pc_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            pc_mem_q[i]   <= '0;
            word_mem_q[i] <= '0;
         end
      end else if (push) begin
         pc_mem_q[wr_ptr_q]   <= fetch_pc_q;
         word_mem_q[wr_ptr_q] <= otp_pdataout;
      end
   end

`ifdef IFETCH_PERF_CNT_EN
   logic [31:0] perf_cnt_q, perf_cnt_d;

   // Counts every accepted word; redirects deliberately do not clear it.
   always_comb begin
      perf_cnt_d = perf_cnt_q;
      if (push) begin
         perf_cnt_d = perf_cnt_q + 32'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         perf_cnt_q <= '0;
      end else begin
         perf_cnt_q <= perf_cnt_d;
      end
   end

   assign perf_fetch_cnt = perf_cnt_q;
`else
   assign perf_fetch_cnt = 32'h0;
`endif

endmodule

// File: doc/ifetch_prefetch.md
# ifetch_prefetch

Instruction fetch/prefetch stage sitting directly upstream of the OTP instruction memory. It owns the fetch PC, drives the OTP byte address bus, and captures the combinationally returned 32-bit instruction words into a small FIFO. It presents them to decode over a valid/ready handshake. Branch/jump redirects from execute flush the FIFO and restart fetch at the new PC.

## Interface
- DEPTH, 2: prefetch FIFO entries; power of two, 2..8.
- RESET_PC, 32'h0000_0000: fetch PC after reset; bits [1:0] must be 0.
- clk  input  1  core clock; all state updates on rising edge.
- rst  input  1  reset, synchronous and active-high.
- otp_pa  output  32  byte address to OTP (`pa`); equals fetch_pc.
- otp_pdataout  input  32  instruction word from OTP (`pdataout`), combinational from otp_pa.
- fetch_en  input  1  1 = fetch allowed; 0 = hold fetch_pc, no FIFO writes.
- redirect_valid  input  1  flush and restart fetch at redirect_pc.
- redirect_pc  input  32  new fetch address; bits [1:0] ignored (forced 0).
- instr_valid  output  1  FIFO head holds a valid instruction.
- instr_ready  input  1  decode accepts head this cycle.
- instr  output  32  FIFO head instruction word.
- instr_pc  output  32  byte address instr was fetched from.
- perf_fetch_cnt  output  32  fetched-word counter (see Configuration).

## Operation
- Registers: fetch_pc[31:0], FIFO of DEPTH entries {pc, word}, wr_ptr/rd_ptr (log2 DEPTH bits, wrap), count (0..DEPTH).
- otp_pa = fetch_pc, combinational, no other logic on path.
- pop = instr_valid && instr_ready.
- push = fetch_en && !redirect_valid && (count < DEPTH || pop).
- On push: FIFO[wr_ptr] <= {fetch_pc, otp_pdataout}; wr_ptr++; fetch_pc <= fetch_pc + 4 (mod 2^32; 32'hFFFF_FFFC wraps to 0).
- On pop: rd_ptr++. count += push - pop.
- instr_valid = (count != 0); instr/instr_pc driven from FIFO[rd_ptr].
- Redirect (highest priority): count, wr_ptr, rd_ptr <= 0; fetch_pc <= {redirect_pc[31:2], 2'b00}; no push; pop handshake that cycle counts as consumed but entry is discarded anyway.
- fetch_en=0: no push, fetch_pc held; pops continue normally.
- Full and pop same cycle: push permitted, count unchanged.
- Empty and push same cycle: no bypass; word visible next cycle.

## Timing
- Reset values: fetch_pc=RESET_PC (otp_pa=RESET_PC), count=0, pointers=0, instr_valid=0, instr/instr_pc=0 (FIFO storage cleared), perf_fetch_cnt=0.
- First word: first edge with rst=0 and fetch_en=1 pushes mem[RESET_PC]; instr_valid=1 the following cycle.
- Fetch-to-valid latency 1 cycle; sustained throughput 1 word/cycle with instr_ready held 1.
- Redirect at edge N: instr_valid=0 in cycle N+1, otp_pa=redirect_pc in N+1, first new word valid in N+2.
- rst asserted mid-operation overrides redirect and all pushes/pops; full reset state after that edge.
- instr/instr_pc stable while instr_valid=1 and instr_ready=0.

## Configuration
- IFETCH_PERF_CNT_EN defined: perf_fetch_cnt increments by 1 on every push (wraps at 2^32), reset to 0 by rst, not cleared by redirect.
- Not defined: counter logic removed; perf_fetch_cnt tied to 32'h0.

## Test plan
- Reset then fetch_en=1, instr_ready=1, OTP model = word index: instr_pc sequence 0,4,8,… with instr 0,1,2,…, instr_valid continuous from 2nd cycle after reset release.
- instr_ready=0 for 5 cycles, DEPTH=2: exactly 2 pushes, otp_pa stalls at 8, head stays pc 0; releasing ready resumes 1/cycle with no lost or duplicated pc.
- Redirect to 32'h0000_0103 while FIFO full: instr_valid=0 next cycle, otp_pa=32'h100, next valid instr_pc=32'h100; old entries never appear.
- Redirect and push/pop same cycle, plus rst asserted same cycle as redirect: rst wins, otp_pa=RESET_PC, count=0.
- redirect_pc=32'hFFFF_FFF8: instr_pc sequence FFFF_FFF8, FFFF_FFFC, 0000_0000.
- With IFETCH_PERF_CNT_EN: 10 pushes then redirect then 3 pushes → perf_fetch_cnt=13; without macro → 0 throughout.
